// File: rtl/pipeline_exec_controller_pkg.sv
// rtl/pipeline_exec_controller_pkg.sv - shared state/command encodings for the execution controller
package pipeline_exec_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } exec_state_e;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_PAUSE = 2'b11
    } exec_cmd_e;

    localparam int NB_CYCLES_DEFAULT = 32;

endpackage

// File: rtl/pipeline_exec_controller_sat_counter.sv
// rtl/pipeline_exec_controller_sat_counter.sv - saturating up-counter with sync clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear has priority; otherwise count up when enabled and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, asynchronously cleared by the active-low reset.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_exec_controller.sv
// rtl/pipeline_exec_controller.sv - run/step/pause/clear sequencer with HALT drain for the pipeline
module pipeline_exec_controller
    import pipeline_exec_controller_pkg::*;
#(
    parameter int NB_CYCLES    = NB_CYCLES_DEFAULT,
    parameter int NB_DRAIN     = 3,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt_id,
    input  logic                 i_halt_wb,
    output logic                 o_pipe_enable,
    output logic                 o_pc_enable,
    output logic                 o_ctrl_squash,
    output logic                 o_done,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    exec_state_e         state_q, state_d;
    logic                halt_pending_q, halt_pending_d;
    logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
    logic                pipe_en;
    logic                cmd_fire;
    logic                clear_all;
    logic                drain_done;

    assign pipe_en  = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign cmd_fire = i_cmd_valid && o_cmd_ready;

    // Next-state logic: command decode, halt capture and drain countdown; drain completion beats PAUSE.
    always_comb begin
        state_d        = state_q;
        halt_pending_d = halt_pending_q;
        drain_cnt_d    = drain_cnt_q;
        clear_all      = 1'b0;
        drain_done     = 1'b0;

        if (pipe_en) begin
            if (halt_pending_q) begin
                drain_cnt_d = drain_cnt_q - 1'b1;
                drain_done  = (drain_cnt_q == NB_DRAIN'(1)) || i_halt_wb;
            end else if (i_halt_id) begin
                halt_pending_d = 1'b1;
                drain_cnt_d    = NB_DRAIN'(DRAIN_CYCLES);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    case (exec_cmd_e'(i_cmd))
                        CMD_RUN:   state_d = ST_RUN;
                        CMD_STEP:  state_d = ST_STEP;
                        CMD_CLEAR: clear_all = 1'b1;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RUN: begin
                if (cmd_fire && (exec_cmd_e'(i_cmd) == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                state_d = ST_IDLE;
            end
            default: begin
                if (cmd_fire && (exec_cmd_e'(i_cmd) == CMD_CLEAR)) begin
                    clear_all = 1'b1;
                end
            end
        endcase

        if (drain_done) begin
            state_d = ST_DONE;
        end

        if (clear_all) begin
            state_d        = ST_IDLE;
            halt_pending_d = 1'b0;
            drain_cnt_d    = '0;
        end
    end

    // State, halt flag and drain counter registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q        <= ST_IDLE;
            halt_pending_q <= 1'b0;
            drain_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            halt_pending_q <= halt_pending_d;
            drain_cnt_q    <= drain_cnt_d;
        end
    end

    sat_counter #(
        .WIDTH (NB_CYCLES)
    ) u_cycle_counter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (clear_all),
        .i_enable (pipe_en),
        .o_count  (o_cycle_count)
    );

    assign o_pipe_enable = pipe_en;
    assign o_cmd_ready   = (state_q != ST_STEP);
    assign o_done        = (state_q == ST_DONE);
    assign o_ctrl_squash = halt_pending_q;
    assign o_pc_enable   = pipe_en && !halt_pending_q && !i_halt_id;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// tb/tb_pipeline_exec_controller.sv - directed and randomized checks of pipeline_exec_controller
module tb_pipeline_exec_controller;

    localparam int DRAIN = 4;
    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_PAUSE = 2'b11;
    localparam longint unsigned MAX_BIG   = 64'h0000_0000_FFFF_FFFF;
    localparam longint unsigned MAX_SMALL = 64'd15;

    // Model modes.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;
    localparam int M_DONE = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        halt_id = 1'b0;
    logic        halt_wb = 1'b0;

    logic        cmd_ready, pipe_en, pc_en, squash, done;
    logic [31:0] cnt;
    logic        s_cmd_ready, s_pipe_en, s_pc_en, s_squash, s_done;
    logic [3:0]  s_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int              m_mode;
    bit              m_pend;
    int              m_left;
    longint unsigned m_count;

    always #5 clk = ~clk;

    pipeline_exec_controller #(.NB_CYCLES(32), .NB_DRAIN(3), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .o_cmd_ready   (cmd_ready),
        .i_halt_id     (halt_id),
        .i_halt_wb     (halt_wb),
        .o_pipe_enable (pipe_en),
        .o_pc_enable   (pc_en),
        .o_ctrl_squash (squash),
        .o_done        (done),
        .o_cycle_count (cnt)
    );

    pipeline_exec_controller #(.NB_CYCLES(4), .NB_DRAIN(3), .DRAIN_CYCLES(DRAIN)) dut_s (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .o_cmd_ready   (s_cmd_ready),
        .i_halt_id     (halt_id),
        .i_halt_wb     (halt_wb),
        .o_pipe_enable (s_pipe_en),
        .o_pc_enable   (s_pc_en),
        .o_ctrl_squash (s_squash),
        .o_done        (s_done),
        .o_cycle_count (s_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pend  = 1'b0;
        m_left  = 0;
        m_count = 0;
    endtask

    // Drive one cycle: apply inputs after the falling edge, compare, then advance the model.
    task automatic do_cycle(input bit v, input logic [1:0] c, input bit hid, input bit hwb);
        bit en;
        bit acc;
        bit finish;
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        halt_id   = hid;
        halt_wb   = hwb;
        #1;
        en = (m_mode == M_RUN) || (m_mode == M_STEP);
        check("pipe_enable", {63'd0, pipe_en}, {63'd0, en});
        check("cmd_ready", {63'd0, cmd_ready}, {63'd0, m_mode != M_STEP});
        check("done", {63'd0, done}, {63'd0, m_mode == M_DONE});
        check("squash", {63'd0, squash}, {63'd0, m_pend});
        check("pc_enable", {63'd0, pc_en}, {63'd0, en && !m_pend && !hid});
        check("cycle_count", {32'd0, cnt}, m_count);
        check("cycle_count_sat4", {60'd0, s_cnt}, (m_count > MAX_SMALL) ? MAX_SMALL : m_count);

        acc    = v && (m_mode != M_STEP);
        finish = 1'b0;
        if (en) begin
            if (m_count < MAX_BIG) m_count++;
            if (m_pend) begin
                m_left--;
                if (m_left == 0 || hwb) finish = 1'b1;
            end else if (hid) begin
                m_pend = 1'b1;
                m_left = DRAIN;
            end
        end
        if (finish) begin
            m_mode = M_DONE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (acc && c == C_RUN) m_mode = M_RUN;
                    else if (acc && c == C_STEP) m_mode = M_STEP;
                    else if (acc && c == C_CLEAR) model_reset();
                end
                M_RUN:  if (acc && c == C_PAUSE) m_mode = M_IDLE;
                M_STEP: m_mode = M_IDLE;
                default: if (acc && c == C_CLEAR) model_reset();
            endcase
        end
    endtask

    initial begin
        model_reset();
        // Reset state
        rst_n = 1'b0;
        #2;
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_pipe", {63'd0, pipe_en}, 64'd0);
        check("rst_count", {32'd0, cnt}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // RUN, ten enabled cycles, PAUSE accepted in the tenth
        do_cycle(0, C_CLEAR, 0, 0);
        do_cycle(1, C_RUN, 0, 0);
        for (int i = 1; i <= 10; i++) do_cycle(i == 10, C_PAUSE, 0, 0);
        do_cycle(0, C_CLEAR, 0, 0);
        check("pause_pipe_low", {63'd0, pipe_en}, 64'd0);
        check("pause_count_10", {32'd0, cnt}, 64'd10);

        // Three single-cycle steps; RUN offered during a step must be refused
        do_cycle(1, C_CLEAR, 0, 0);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1, C_STEP, 0, 0);
            do_cycle(1, C_RUN, 0, 0);
        end
        do_cycle(0, C_CLEAR, 0, 0);
        check("step_count_3", {32'd0, cnt}, 64'd3);

        // HALT in enabled cycle 5, full drain
        do_cycle(1, C_CLEAR, 0, 0);
        do_cycle(1, C_RUN, 0, 0);
        for (int i = 1; i <= 9; i++) do_cycle(0, C_CLEAR, i == 5, 0);
        do_cycle(0, C_CLEAR, 0, 0);
        check("halt_done", {63'd0, done}, 64'd1);
        check("halt_count_9", {32'd0, cnt}, 64'd9);

        // HALT in cycle 5, early drain end via HALT in WB in cycle 7
        do_cycle(1, C_CLEAR, 0, 0);
        do_cycle(1, C_RUN, 0, 0);
        for (int i = 1; i <= 7; i++) do_cycle(0, C_CLEAR, i == 5, i == 7);
        do_cycle(1, C_PAUSE, 0, 0);
        check("wb_done", {63'd0, done}, 64'd1);
        check("wb_count_7", {32'd0, cnt}, 64'd7);

        // Halt while stepping, drained one step at a time, then CLEAR
        do_cycle(1, C_CLEAR, 0, 0);
        do_cycle(1, C_STEP, 0, 0);
        do_cycle(0, C_CLEAR, 1, 0);
        for (int i = 0; i < 4; i++) begin
            do_cycle(1, C_STEP, 0, 0);
            do_cycle(0, C_CLEAR, 0, 0);
        end
        do_cycle(1, C_CLEAR, 0, 0);
        do_cycle(0, C_CLEAR, 0, 0);
        check("stephalt_count_0", {32'd0, cnt}, 64'd0);
        check("stephalt_squash_0", {63'd0, squash}, 64'd0);

        // Asynchronous reset in the middle of a drain
        do_cycle(1, C_RUN, 0, 0);
        do_cycle(0, C_CLEAR, 1, 0);
        do_cycle(0, C_CLEAR, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_pipe", {63'd0, pipe_en}, 64'd0);
        check("async_rst_squash", {63'd0, squash}, 64'd0);
        check("async_rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("async_rst_count", {32'd0, cnt}, 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // HALT with pipe disabled is ignored
        do_cycle(0, C_CLEAR, 1, 0);
        do_cycle(0, C_CLEAR, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            do_cycle($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                     $urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
